// File: rtl/data_mem_responder.sv
// Word-addressed 16-bit data memory answering one load/store request at a time
// after a fixed wait of LATENCY cycles, flagging misaligned and out-of-range accesses.
module data_mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_r;
   logic [3:0]         cnt_r;
   logic               write_r;
   logic [15:0]        addr_r;
   logic [15:0]        wdata_r;
   logic               req_ready_r;
   logic               rsp_valid_r;
   logic               rsp_err_r;
   logic [15:0]        rsp_rdata_r;
   logic [15:0]        mem_r [DEPTH];

   logic               accept_s;
   logic               enter_resp_s;
   logic               acc_write_s;
   logic [15:0]        acc_addr_s;
   logic [15:0]        acc_wdata_s;
   logic               acc_err_s;
   logic [IDX_W-1:0]   acc_idx_s;
   logic               commit_s;
   logic [15:0]        rd_data_s;

   // Select the request being resolved: live inputs only when entering RESP straight from IDLE.
   always_comb begin
      accept_s     = req_valid && req_ready_r;
      enter_resp_s = 1'b0;
      acc_write_s  = write_r;
      acc_addr_s   = addr_r;
      acc_wdata_s  = wdata_r;
      case (state_r)
         IDLE: begin
            enter_resp_s = accept_s && (LATENCY == 0);
            acc_write_s  = req_write;
            acc_addr_s   = req_addr;
            acc_wdata_s  = req_wdata;
         end
         WAIT:    enter_resp_s = (cnt_r == 4'd0);
         default: enter_resp_s = 1'b0;
      endcase
      // No wrap-around: any word index at or beyond DEPTH is an error.
      acc_err_s = acc_addr_s[0] || ({17'd0, acc_addr_s[15:1]} >= 32'(DEPTH));
      acc_idx_s = acc_addr_s[IDX_W:1];
      commit_s  = enter_resp_s && acc_write_s && !acc_err_s;
      rd_data_s = (acc_write_s || acc_err_s) ? 16'd0 : mem_r[acc_idx_s];
   end

   // Store commit on the edge entering RESP; contents are never cleared by reset.
   always_ff @(posedge clock) begin
      if (reset_n && commit_s) begin
         mem_r[acc_idx_s] <= acc_wdata_s;
      end
   end

   // Request/response state machine with registered handshake and response outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         write_r     <= 1'b0;
         addr_r      <= 16'd0;
         wdata_r     <= 16'd0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 16'd0;
         rsp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  write_r     <= req_write;
                  addr_r      <= req_addr;
                  wdata_r     <= req_wdata;
                  req_ready_r <= 1'b0;
                  if (enter_resp_s) begin
                     state_r     <= RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_rdata_r <= rd_data_s;
                     rsp_err_r   <= acc_err_s;
                  end else begin
                     state_r <= WAIT;
                     cnt_r   <= LAT_M1;
                  end
               end
            end
            WAIT: begin
               if (enter_resp_s) begin
                  state_r     <= RESP;
                  rsp_valid_r <= 1'b1;
                  rsp_rdata_r <= rd_data_s;
                  rsp_err_r   <= acc_err_s;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_r     <= IDLE;
                  req_ready_r <= 1'b1;
                  rsp_valid_r <= 1'b0;
                  rsp_rdata_r <= 16'd0;
                  rsp_err_r   <= 1'b0;
               end
            end
            default: begin
               state_r     <= IDLE;
               cnt_r       <= 4'd0;
               req_ready_r <= 1'b1;
               rsp_valid_r <= 1'b0;
               rsp_rdata_r <= 16'd0;
               rsp_err_r   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0, sharing clock and reset.
module tb_data_mem_responder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        sel;
   int          n_checks = 0;
   int          n_fails  = 0;

   logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [15:0] b_req_addr, b_req_wdata, b_rsp_rdata;

   logic        rr, rv, re;
   logic [15:0] rd;

   always #5 clock = ~clock;

   data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut_a (
      .clock(clock), .reset_n(reset_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   data_mem_responder #(.DEPTH(256), .LATENCY(0)) u_dut_b (
      .clock(clock), .reset_n(reset_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   assign rr = sel ? b_req_ready : a_req_ready;
   assign rv = sel ? b_rsp_valid : a_rsp_valid;
   assign rd = sel ? b_rsp_rdata : a_rsp_rdata;
   assign re = sel ? b_rsp_err   : a_rsp_err;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
      if (sel) begin
         b_req_valid = v; b_req_write = w; b_req_addr = a; b_req_wdata = d;
      end else begin
         a_req_valid = v; a_req_write = w; a_req_addr = a; a_req_wdata = d;
      end
   endtask

   // Wait (bounded) for req_ready, then present the request for exactly one edge.
   task automatic accept(input logic w, input logic [15:0] a, input logic [15:0] d);
      int k = 0;
      while (!rr && k < 20) begin
         step();
         k++;
      end
      if (!rr) chk("ready_timeout", 32'(rr), 32'd1);
      drive(1'b1, w, a, d);
      step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   // Count cycles from the acceptance edge until rsp_valid; 1 means the cycle right after it.
   task automatic wait_rsp(output int n, output logic [15:0] data, output logic err);
      n = 1;
      while (!rv && n < 20) begin
         step();
         n++;
      end
      if (!rv) chk("rsp_timeout", 32'(rv), 32'd1);
      data = rd;
      err  = re;
   endtask

   task automatic xact(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input int exp_lat, input logic [15:0] exp_data, input logic exp_err);
      int          n;
      logic [15:0] data;
      logic        err;
      accept(w, a, d);
      wait_rsp(n, data, err);
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_rdata"}, 32'(data), 32'(exp_data));
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      step();
      chk({tag, "_ready_after"}, 32'(rr), 32'd1);
   endtask

   initial begin
      int          n;
      logic [15:0] data;
      logic        err;

      sel = 1'b0;
      reset_n = 1'b0;
      a_rsp_ready = 1'b1;
      b_rsp_ready = 1'b1;
      drive(1'b1, 1'b0, 16'h0010, 16'h0000);
      sel = 1'b1;
      drive(1'b1, 1'b0, 16'h0010, 16'h0000);
      sel = 1'b0;
      step();
      step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      sel = 1'b1;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      sel = 1'b0;
      reset_n = 1'b1;
      step();
      chk("rst_req_ready", 32'(rr), 32'd1);
      chk("rst_rsp_valid", 32'(rv), 32'd0);
      chk("rst_rsp_rdata", 32'(rd), 32'd0);
      chk("rst_rsp_err", 32'(re), 32'd0);

      // Basic store/load, errors, boundaries (LATENCY=2)
      xact("st10",   1'b1, 16'h0010, 16'h00AB, 3, 16'h0000, 1'b0);
      xact("ld10",   1'b0, 16'h0010, 16'h0000, 3, 16'h00AB, 1'b0);
      xact("ld11",   1'b0, 16'h0011, 16'h0000, 3, 16'h0000, 1'b1);
      xact("ld200",  1'b0, 16'h0200, 16'h0000, 3, 16'h0000, 1'b1);
      xact("st11",   1'b1, 16'h0011, 16'hFFFF, 3, 16'h0000, 1'b1);
      xact("ld10b",  1'b0, 16'h0010, 16'h0000, 3, 16'h00AB, 1'b0);
      xact("st0",    1'b1, 16'h0000, 16'h1111, 3, 16'h0000, 1'b0);
      xact("st200",  1'b1, 16'h0200, 16'h5555, 3, 16'h0000, 1'b1);
      xact("ld0",    1'b0, 16'h0000, 16'h0000, 3, 16'h1111, 1'b0);
      xact("st1fe",  1'b1, 16'h01FE, 16'h7E7E, 3, 16'h0000, 1'b0);
      xact("ld1fe",  1'b0, 16'h01FE, 16'h0000, 3, 16'h7E7E, 1'b0);
      xact("ldffff", 1'b0, 16'hFFFF, 16'h0000, 3, 16'h0000, 1'b1);

      // Backpressure: hold rsp_ready low for 5 cycles in RESP
      a_rsp_ready = 1'b0;
      accept(1'b0, 16'h0010, 16'h0000);
      wait_rsp(n, data, err);
      chk("bp_lat", 32'(n), 32'd3);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(rv), 32'd1);
         chk("bp_rdata", 32'(rd), 32'h00AB);
         chk("bp_err", 32'(re), 32'd0);
         chk("bp_ready", 32'(rr), 32'd0);
         step();
      end
      a_rsp_ready = 1'b1;
      step();
      a_rsp_ready = 1'b0;
      chk("bp_ready_after", 32'(rr), 32'd1);
      chk("bp_valid_after", 32'(rv), 32'd0);
      a_rsp_ready = 1'b1;

      // Reset mid-WAIT discards a pending store
      xact("st20",   1'b1, 16'h0020, 16'h0001, 3, 16'h0000, 1'b0);
      accept(1'b1, 16'h0020, 16'hBEEF);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("rw_valid", 32'(rv), 32'd0);
         chk("rw_ready", 32'(rr), 32'd1);
         step();
      end
      xact("ld20",   1'b0, 16'h0020, 16'h0000, 3, 16'h0001, 1'b0);

      // Back-to-back with req_valid held and addresses changing while busy
      drive(1'b1, 1'b0, 16'h0010, 16'h0000);
      step();
      drive(1'b1, 1'b0, 16'h0020, 16'h0000);
      chk("b2b_ready_wait", 32'(rr), 32'd0);
      step();
      drive(1'b1, 1'b0, 16'h0030, 16'h0000);
      chk("b2b_valid_early", 32'(rv), 32'd0);
      step();
      chk("b2b_valid", 32'(rv), 32'd1);
      chk("b2b_rdata", 32'(rd), 32'h00AB);
      chk("b2b_ready_resp", 32'(rr), 32'd0);
      drive(1'b1, 1'b0, 16'h0020, 16'h0000);
      step();
      chk("b2b_ready_hs", 32'(rr), 32'd1);
      chk("b2b_valid_hs", 32'(rv), 32'd0);
      step();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("b2b_ready_acc2", 32'(rr), 32'd0);
      wait_rsp(n, data, err);
      chk("b2b2_lat", 32'(n), 32'd3);
      chk("b2b2_rdata", 32'(data), 32'h0001);
      step();

      // LATENCY=0 instance
      sel = 1'b1;
      xact("z_st2",  1'b1, 16'h0002, 16'h1234, 1, 16'h0000, 1'b0);
      xact("z_ld2",  1'b0, 16'h0002, 16'h0000, 1, 16'h1234, 1'b0);
      xact("z_ld3",  1'b0, 16'h0003, 16'h0000, 1, 16'h0000, 1'b1);
      xact("z_ld200",1'b0, 16'h0200, 16'h0000, 1, 16'h0000, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, 256, number of 16-bit words stored; legal word indices 0..DEPTH-1.
REQ-002 Parameter LATENCY, 2, wait cycles between request acceptance and response; legal range 0..15.
REQ-003 clock  input  1  single clock; all state changes on posedge clock.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
REQ-005 req_valid  input  1  requester (CPU load/store stage) presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store (SW), 0 = load (LW).
REQ-008 req_addr  input  16  byte address; word index = req_addr[15:1].
REQ-009 req_wdata  input  16  store data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester consumes the response.
REQ-012 rsp_rdata  output  16  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-014 States SHALL be IDLE, WAIT, RESP; one request outstanding at most.
REQ-015 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready at a posedge.
REQ-016 On acceptance the block SHALL latch req_write, req_addr, req_wdata; later input changes have no effect on the accepted request.
REQ-017 IDLE -> WAIT on acceptance when LATENCY > 0, loading the wait counter with LATENCY-1; IDLE -> RESP directly when LATENCY = 0.
REQ-018 In WAIT the counter SHALL decrement each cycle; WAIT -> RESP on the cycle the counter is 0.
REQ-019 rsp_valid SHALL assert exactly LATENCY+1 cycles after the acceptance edge and SHALL be 1 only in RESP.
REQ-020 The memory access (read capture or write commit) SHALL occur on the edge entering RESP; a store is not visible before that edge.
REQ-021 rsp_rdata and rsp_err SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-022 RESP -> IDLE on rsp_valid & rsp_ready; req_ready returns to 1 the cycle after the handshake (no same-cycle accept).
REQ-023 Misaligned request (latched req_addr[0]=1): no memory access, rsp_err=1, rsp_rdata=0, same latency as a normal request.
REQ-024 Out-of-range request (latched req_addr[15:1] >= DEPTH): no memory access, rsp_err=1, rsp_rdata=0; misaligned takes no extra priority, both report rsp_err=1.
REQ-025 Store response SHALL carry rsp_err=0, rsp_rdata=0 when legal.
REQ-026 Load following a store to the same word SHALL return the stored value.
REQ-027 Addresses SHALL not wrap: index DEPTH is an error, never aliasing to index 0.

Reset
REQ-028 With reset_n=0 at a posedge: state=IDLE, wait counter=0, req_ready=1 on the following cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 Reset SHALL override any simultaneous acceptance or response handshake in the same cycle.
REQ-030 Reset in WAIT SHALL discard the pending request; a pending store SHALL NOT be committed.
REQ-031 Reset in RESP SHALL drop the response; an already-committed store remains in memory.
REQ-032 Memory contents SHALL NOT be cleared by reset; contents before the first store are undefined.

Verification
REQ-033 LATENCY=2: store addr 0x0010 data 0x00AB, rsp_ready=1 -> rsp_valid at acceptance+3, rsp_err=0, rsp_rdata=0; then load 0x0010 -> rsp_rdata=0x00AB.
REQ-034 LATENCY=0: load after store of 0x1234 to addr 0x0002 -> rsp_valid on cycle after acceptance, rsp_rdata=0x1234.
REQ-035 Misaligned load addr 0x0011 and out-of-range load addr 0x0200 (DEPTH=256) -> rsp_err=1, rsp_rdata=0, no memory change (reload 0x0010 still 0x00AB).
REQ-036 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err constant, req_ready=0 throughout; req_ready=1 one cycle after rsp_ready pulses.
REQ-037 Reset mid-WAIT during store of 0xBEEF to 0x0020 (prior value 0x0001) -> rsp_valid never asserts, req_ready=1 after reset, load 0x0020 returns 0x0001.
REQ-038 Back-to-back: req_valid held high with changing req_addr during WAIT/RESP -> only the latched request is serviced; the next acceptance occurs no earlier than the cycle after the response handshake.
